// File: rtl/present_round_ctrl.sv
// Round sequencer for the 12-bit PRESENT S-box/key-add datapath; each round runs twice (CALC, CHECK) and commits only on a match.
// Latency: start accepted at edge 0, io_done pulses at edge 2*ROUNDS; a mismatch sets io_fault at the edge closing the failing CHECK.
// Backpressure: none; io_start is ignored while busy (no queuing), and operand inputs are only sampled on an accepted start.
module present_round_ctrl #(
    parameter int ROUNDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_start,
    input  logic [11:0] io_plaintext,
    input  logic [11:0] io_key,
    output logic [11:0] io_dp_state,
    output logic [11:0] io_dp_key,
    input  logic [11:0] io_dp_out,
    output logic        io_busy,
    output logic        io_done,
    output logic        io_fault,
    output logic [11:0] io_out
);

    // DONE is split in two so io_done can be decoded purely from the state
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE1 = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } fsm_t;

    localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

    fsm_t        r_fsm;
    fsm_t        w_fsm_nxt;
    logic [11:0] r_state;
    logic [11:0] r_key;
    logic [11:0] r_tmp;
    logic [11:0] r_out;
    logic [3:0]  r_rnd;
    logic        r_fault;

    logic        w_match;
    logic        w_last;
    logic        w_load;
    logic        w_cap;
    logic        w_commit;
    logic        w_finish;
    logic        w_abort;

    assign w_match = (io_dp_out == r_tmp);
    assign w_last  = (r_rnd == LAST_RND);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Next-state and per-phase register strobes
    always_comb begin
        w_fsm_nxt = r_fsm;
        w_load    = 1'b0;
        w_cap     = 1'b0;
        w_commit  = 1'b0;
        w_finish  = 1'b0;
        w_abort   = 1'b0;
        case (r_fsm)
            S_IDLE, S_DONE1, S_DONE, S_FAULT: begin
                if (io_start) begin
                    w_load    = 1'b1;
                    w_fsm_nxt = S_CALC;
                end else if (r_fsm == S_DONE1) begin
                    w_fsm_nxt = S_DONE;
                end
            end
            S_CALC: begin
                w_cap     = 1'b1;
                w_fsm_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (w_match) begin
                    w_commit = 1'b1;
                    if (w_last) begin
                        w_finish  = 1'b1;
                        w_fsm_nxt = S_DONE1;
                    end else begin
                        w_fsm_nxt = S_CALC;
                    end
                end else begin
                    w_abort   = 1'b1;
                    w_fsm_nxt = S_FAULT;
                end
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    // Operand, capture, round counter and result registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= 12'h000;
            r_key   <= 12'h000;
            r_tmp   <= 12'h000;
            r_out   <= 12'h000;
            r_rnd   <= 4'd0;
            r_fault <= 1'b0;
        end else begin
            if (w_load) begin
                r_state <= io_plaintext;
                r_key   <= io_key;
                r_rnd   <= 4'd0;
                r_fault <= 1'b0;
            end
            if (w_cap) begin
                r_tmp <= io_dp_out;
            end
            if (w_commit) begin
                r_state <= io_dp_out;
                if (w_finish) begin
                    r_out <= io_dp_out;
                end else begin
                    r_rnd <= r_rnd + 4'd1;
                end
            end
            if (w_abort) begin
                r_fault <= 1'b1;
                r_out   <= 12'h000;
                r_state <= 12'h000;
            end
        end
    end

    // Round counter sits in the low nibble of the round key with no carry
    assign io_dp_state = r_state;
    assign io_dp_key   = r_key ^ {8'h00, r_rnd};
    assign io_busy     = (r_fsm == S_CALC) || (r_fsm == S_CHECK);
    assign io_done     = (r_fsm == S_DONE1);
    assign io_fault    = r_fault;
    assign io_out      = r_out;

endmodule

// File: tb/tb_present_round_ctrl.sv
module tb_present_round_ctrl;

    localparam int R  = 4;
    localparam int MI = 0;
    localparam int MB = 1;
    localparam int MD = 2;
    localparam int MF = 3;

    logic        clock;
    logic        reset;
    logic        io_start;
    logic [11:0] io_plaintext;
    logic [11:0] io_key;
    logic [11:0] dp_state, dp_key, dp_out;
    logic        busy, done, fault;
    logic [11:0] out;
    logic [11:0] inj_mask;
    logic        stuck;

    logic        r1_start;
    logic [11:0] r1_pt, r1_key;
    logic [11:0] r1_dp_state, r1_dp_key, r1_dp_out;
    logic        r1_busy, r1_done, r1_fault;
    logic [11:0] r1_out;

    int n_checks = 0;
    int n_err    = 0;
    logic chk_en = 1'b0;

    // behavioural reference
    int          m_mode;
    int          m_ph;
    logic [11:0] m_state, m_key, m_tmp, m_out;
    logic        m_fault, m_done;

    function automatic logic [3:0] sb(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [11:0] dp_fn(input logic [11:0] s, input logic [11:0] k,
                                          input logic [11:0] inj, input logic st);
        logic [11:0] v;
        v = {sb(s[11:8]), sb(s[7:4]), sb(s[3:0])} ^ k ^ inj;
        if (st) v[0] = 1'b1;
        return v;
    endfunction

    function automatic logic [11:0] rnd12();
        return 12'($urandom);
    endfunction

    assign dp_out    = dp_fn(dp_state, dp_key, inj_mask, stuck);
    assign r1_dp_out = dp_fn(r1_dp_state, r1_dp_key, 12'h000, 1'b0);

    present_round_ctrl #(.ROUNDS(R)) u_dut (
        .clock(clock), .reset(reset), .io_start(io_start),
        .io_plaintext(io_plaintext), .io_key(io_key),
        .io_dp_state(dp_state), .io_dp_key(dp_key), .io_dp_out(dp_out),
        .io_busy(busy), .io_done(done), .io_fault(fault), .io_out(out)
    );

    present_round_ctrl #(.ROUNDS(1)) u_r1 (
        .clock(clock), .reset(reset), .io_start(r1_start),
        .io_plaintext(r1_pt), .io_key(r1_key),
        .io_dp_state(r1_dp_state), .io_dp_key(r1_dp_key), .io_dp_out(r1_dp_out),
        .io_busy(r1_busy), .io_done(r1_done), .io_fault(r1_fault), .io_out(r1_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = MI;
        m_ph    = 0;
        m_state = 12'h000;
        m_key   = 12'h000;
        m_tmp   = 12'h000;
        m_out   = 12'h000;
        m_fault = 1'b0;
        m_done  = 1'b0;
    endtask

    // What the next rising edge must do, from the current inputs
    task automatic model_step();
        logic [11:0] v;
        m_done = 1'b0;
        if (m_mode != MB) begin
            if (io_start) begin
                m_state = io_plaintext;
                m_key   = io_key;
                m_ph    = 0;
                m_fault = 1'b0;
                m_mode  = MB;
            end
        end else begin
            v = dp_fn(m_state, m_key ^ 12'(m_ph / 2), inj_mask, stuck);
            if (m_ph % 2 == 0) begin
                m_tmp = v;
                m_ph++;
            end else if (v != m_tmp) begin
                m_fault = 1'b1;
                m_out   = 12'h000;
                m_state = 12'h000;
                m_mode  = MF;
            end else begin
                m_state = v;
                if (m_ph == 2 * R - 1) begin
                    m_out  = v;
                    m_mode = MD;
                    m_done = 1'b1;
                end else begin
                    m_ph++;
                end
            end
        end
    endtask

    // Compare DUT against the model every cycle, away from the rising edge
    always @(negedge clock) begin
        if (chk_en) begin
            chk("m_busy",  12'(busy),  12'(m_mode == MB));
            chk("m_done",  12'(done),  12'(m_done));
            chk("m_fault", 12'(fault), 12'(m_fault));
            chk("m_out",   out,        m_out);
            chk("m_state", dp_state,   m_state);
            chk("m_key",   dp_key,     m_key ^ 12'(m_ph / 2));
        end
    end

    task automatic cycle(input logic st, input logic [11:0] pt, input logic [11:0] k,
                         input logic [11:0] inj);
        @(negedge clock);
        #1;
        io_start     = st;
        io_plaintext = pt;
        io_key       = k;
        inj_mask     = inj;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, rnd12(), rnd12(), 12'h000);
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        while (done !== 1'b1 && n < lim) begin
            cycle(1'b0, rnd12(), rnd12(), 12'h000);
            n++;
        end
        chk("done_seen", 12'(done), 12'h001);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        prev_done;
        logic [11:0] inj;
        logic        st;

        clock = 1'b0; reset = 1'b0; io_start = 1'b0; io_plaintext = '0; io_key = '0;
        inj_mask = '0; stuck = 1'b0; r1_start = 1'b0; r1_pt = '0; r1_key = '0;
        model_reset();

        // reset state
        #12;
        chk("rst_busy", 12'(busy), 12'h000);
        chk("rst_done", 12'(done), 12'h000);
        chk("rst_fault", 12'(fault), 12'h000);
        chk("rst_out", out, 12'h000);
        chk("rst_dps", dp_state, 12'h000);
        chk("rst_dpk", dp_key, 12'h000);
        @(negedge clock);
        reset = 1'b1;
        #1 chk_en = 1'b1;

        // zero plaintext/key, literal round values
        cycle(1'b1, 12'h000, 12'h000, 12'h000);
        idle(3);
        chk("r0_state", dp_state, 12'hCCC);
        idle(2);
        chk("r1_state", dp_state, 12'h445);
        chk("r2_key", dp_key, 12'h002);
        idle(4);
        chk("z_done", 12'(done), 12'h001);
        chk("z_out", out, 12'hEE5);
        chk("z_fault", 12'(fault), 12'h000);
        idle(1);
        chk("z_done_once", 12'(done), 12'h000);

        // single-round instance
        idle(1);
        r1_start = 1'b1;
        idle(1);
        r1_start = 1'b0;
        chk("r1_busy_a", 12'(r1_busy), 12'h001);
        idle(1);
        chk("r1_busy_b", 12'(r1_busy), 12'h001);
        idle(1);
        chk("r1_done", 12'(r1_done), 12'h001);
        chk("r1_idle", 12'(r1_busy), 12'h000);
        chk("r1_out", r1_out, 12'hCCC);
        chk("r1_fault", 12'(r1_fault), 12'h000);
        idle(1);
        chk("r1_done_once", 12'(r1_done), 12'h000);
        chk("r1_out_hold", r1_out, 12'hCCC);

        // bit flip on round 2 CHECK only
        cycle(1'b1, 12'h000, 12'h000, 12'h000);
        idle(5);
        cycle(1'b0, rnd12(), rnd12(), 12'h020);
        idle(1);
        chk("f_fault", 12'(fault), 12'h001);
        chk("f_out", out, 12'h000);
        chk("f_busy", 12'(busy), 12'h000);
        chk("f_done", 12'(done), 12'h000);
        idle(3);
        chk("f_sticky", 12'(fault), 12'h001);
        cycle(1'b1, 12'h5A3, 12'h1F0, 12'h000);
        idle(1);
        chk("f_clear", 12'(fault), 12'h000);
        wait_done(30);

        // start held high, operands churning
        prev_done = 1'b0;
        for (int i = 0; i < 36; i++) begin
            cycle(1'b1, rnd12(), rnd12(), 12'h000);
            if (prev_done) chk("restart_busy", 12'(busy), 12'h001);
            prev_done = done;
        end

        // asynchronous reset in CALC of round 1
        idle(20);
        cycle(1'b1, 12'h000, 12'h000, 12'h000);
        idle(3);
        #1 reset = 1'b0;
        #1;
        chk("ar_busy", 12'(busy), 12'h000);
        chk("ar_done", 12'(done), 12'h000);
        chk("ar_fault", 12'(fault), 12'h000);
        chk("ar_out", out, 12'h000);
        chk("ar_dps", dp_state, 12'h000);
        chk("ar_dpk", dp_key, 12'h000);
        model_reset();
        io_start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        cycle(1'b1, rnd12(), rnd12(), 12'h000);
        wait_done(30);

        // stuck-at-1 on bit 0 seen identically in both phases
        stuck = 1'b1;
        cycle(1'b1, 12'h000, 12'h000, 12'h000);
        wait_done(30);
        chk("sa_out", out, 12'hEE1);
        chk("sa_fault", 12'(fault), 12'h000);
        idle(1);
        stuck = 1'b0;
        idle(1);

        // random traffic with occasional single-phase bit flips
        for (int i = 0; i < 400; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            inj = 12'h000;
            if ($urandom_range(0, 24) == 0) inj = 12'h001 << $urandom_range(0, 11);
            cycle(st, rnd12(), rnd12(), inj);
        end
        idle(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/present_round_ctrl.md
# present_round_ctrl

Round sequencer with temporal-redundancy fault detection for the 12-bit parallel PRESENT S-box/key-addition datapath, which is three nibble S-boxes each followed by a key XOR. The block owns the state and key registers and drives the combinational datapath once per phase. It evaluates every round twice on identical operands, in a CALC phase and a CHECK phase. It commits the result only if both evaluations match; otherwise it aborts with a sticky fault flag. It sits between the case-study bench/top level and the datapath, so timing faults can be injected and their detection measured.

## Interface
Parameters:
- ROUNDS, default 4: number of rounds, legal range 1..15.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 resets all registers immediately.
- io_start  in  1  start request, sampled only in IDLE, DONE and FAULT.
- io_plaintext  in  12  initial state, latched on an accepted start.
- io_key  in  12  master key, latched on an accepted start.
- io_dp_state  out  12  datapath state operand; equals the state register.
- io_dp_key  out  12  datapath key operand; equals the round key (below).
- io_dp_out  in  12  datapath result: combinational S-box layer then key XOR.
- io_busy  out  1  high in CALC and CHECK.
- io_done  out  1  one-cycle pulse on entry to DONE.
- io_fault  out  1  sticky mismatch flag.
- io_out  out  12  ciphertext; valid from the io_done pulse until the next accepted start.

## Operation
- Registers:
  - state_q[11:0], key_q[11:0].
  - tmp_q[11:0], holding the CALC result.
  - rnd_q[3:0], the round counter.
  - out_q[11:0].
  - A 3-bit FSM.
- Round key: key_q XOR {8'b0, rnd_q}. rnd_q is zero-extended into bits [3:0]; there is no carry.
- FSM states:
  - IDLE: if io_start is high, load state_q←io_plaintext, key_q←io_key, rnd_q←0, io_fault←0, then go to CALC.
  - CALC: tmp_q←io_dp_out, then go to CHECK. The operands are not changed.
  - CHECK, match (io_dp_out == tmp_q):
    - state_q←io_dp_out.
    - If rnd_q == ROUNDS-1: out_q←io_dp_out, then go to DONE.
    - Otherwise: rnd_q←rnd_q+1, then go to CALC.
  - CHECK, mismatch: io_fault←1, out_q←0, state_q←0, then go to FAULT.
  - DONE: io_done is high only on the first cycle in DONE. Holds; a start restarts exactly as from IDLE.
  - FAULT: holds; io_fault stays 1. A start clears io_fault and restarts.
- io_start is ignored while busy; there is no queuing.
- io_plaintext and io_key changes while busy have no effect.

## Timing
- Reset values:
  - FSM = IDLE.
  - All data registers = 0.
  - io_busy, io_done and io_fault = 0.
  - io_out = 0.
  - io_dp_state and io_dp_key = 0.
- Latency:
  - Start is accepted at edge 0.
  - io_busy goes high in the following cycle.
  - Each round takes exactly 2 cycles.
  - DONE is entered, and io_done pulses, at edge 2·ROUNDS after the accepting edge.
- Operands are stable across the CALC/CHECK pair, so a fault in either phase yields a mismatch unless it is identical in both.
- A fault is detected in the same cycle as the failing CHECK. io_fault rises at the next edge, and io_out is 0 from that edge on.
- Start asserted in the same cycle as the DONE entry edge is not seen until DONE. Start asserted in DONE or FAULT restarts at that edge, and io_done is low in the cycle after.
- Reset asserted mid-round aborts immediately: outputs go to their reset values, with no done and no fault.
- ROUNDS=1 gives a single CALC/CHECK pair.

## Test plan
- ROUNDS=1, plaintext 0x000, key 0x000, start for one cycle -> io_busy is high for 2 cycles, then io_done pulses once, io_out=0xCCC, io_fault=0.
- ROUNDS=2, plaintext 0x000, key 0x000 -> round 1 evaluates S(0xCCC)^0x001, giving io_out=0x445 after 4 busy cycles.
- ROUNDS=4, during round 2 the bench flips io_dp_out bit 5 in the CHECK cycle only -> io_fault=1 at the next edge, io_out=0x000, FSM in FAULT, no io_done. A subsequent fault-free start clears io_fault and gives the correct ciphertext.
- Start held high continuously, with plaintext and key changed mid-run -> one computation per run with the originally latched operands. The next run begins the cycle after DONE is entered.
- Reset pulled low in the middle of the CALC phase of round 1 -> all outputs 0 asynchronously, without waiting for a clock edge. After release, a new start runs normally.
- Fault applied identically in both CALC and CHECK (a stuck-at on io_dp_out[0]) -> no fault is flagged and the wrong ciphertext is produced; this documents the detection limit.
